// File: rtl/snn_axi_cfg_slave.sv
// snn_axi_cfg_slave
// AXI4-Lite configuration slave for the SNN core.
//   0x0000 CTRL      RW  (writing bit0=1 while the core is idle fires 'start')
//   0x0004 SIM_TIME  RW
//   0x0008 MEM_CFG   RW
//   0x000C DEBUG     RO  bit0 = busy, other bits 0
//   0x0100-0x01FF    external memory window, ext_mem_addr = ADDR[7:0]
// Register addresses are word decoded; ADDR[1:0] are ignored inside 0x0000-0x000F.
// WSTRB is ignored: every accepted write replaces all 32 bits.
// Optional macro SNN_AXI_SLVERR_EN: accesses to unmapped addresses answer
// SLVERR instead of OKAY. Unmapped reads always return zero.
module snn_axi_cfg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // register contents to the core
  output logic [31:0]                     ctrl_reg,
  output logic [31:0]                     sim_time,
  output logic [31:0]                     mem_cfg,
  output logic                            start,
  input  logic                            busy,
  // external memory window
  output logic                            ext_mem_wr_en,
  output logic                            ext_mem_rd_en,
  output logic [7:0]                      ext_mem_addr,
  output logic [31:0]                     ext_mem_wdata,
  input  logic [31:0]                     ext_mem_rdata
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_FETCH, R_RESP} r_state_e;
  typedef enum logic [2:0] {
    SEL_CTRL, SEL_SIM_TIME, SEL_MEM_CFG, SEL_DEBUG, SEL_WINDOW, SEL_NONE
  } sel_e;

  // Address map: register block in the first 16 bytes, memory window in page 1.
  function automatic sel_e decode(input logic [AW-1:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    if ((addr >> 4) == '0) begin
      case (addr[3:2])
        2'd0: sel = SEL_CTRL;
        2'd1: sel = SEL_SIM_TIME;
        2'd2: sel = SEL_MEM_CFG;
        2'd3: sel = SEL_DEBUG;
      endcase
    end else if ((addr >> 8) == AW'(1)) begin
      sel = SEL_WINDOW;
    end
    return sel;
  endfunction

  w_state_e      w_state;
  r_state_e      r_state;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  sel_e          aw_sel;
  sel_e          ar_sel;
  sel_e          wr_sel;
  sel_e          rd_sel;
  logic          wr_go;
  logic          unused_wstrb;

  assign aw_sel = decode(S_AXI_AWADDR);
  assign ar_sel = decode(S_AXI_ARADDR);
  assign wr_sel = decode(wr_addr);
  assign rd_sel = decode(rd_addr);

  // A write is taken this cycle; the read side yields to it (write wins ties).
  assign wr_go = (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;

  // Write strobes carry no meaning for this register file.
  assign unused_wstrb = ^S_AXI_WSTRB;

  // The window port is shared: wr_en lives in W_ACK and rd_en in R_ACK, which
  // never overlap because R_ACK is never entered on the edge that enters W_ACK.
  assign ext_mem_addr  = ext_mem_rd_en ? rd_addr[7:0] : wr_addr[7:0];
  assign ext_mem_wdata = wr_data;

  // Write FSM: accept address+data together, update the target, hold BVALID.
  // NOTE: async reset only touches flops; every state element here is a flop,
  // and all sequential assignments are non-blocking so the FSMs read
  // pre-edge values of each other regardless of block evaluation order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      wr_addr       <= '0;
      wr_data       <= '0;
      ext_mem_wr_en <= 1'b0;
      ctrl_reg      <= '0;
      sim_time      <= '0;
      mem_cfg       <= '0;
      start         <= 1'b0;
    end else begin
      start <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (wr_go) begin
            w_state       <= W_ACK;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wr_addr       <= S_AXI_AWADDR;
            wr_data       <= S_AXI_WDATA;
            ext_mem_wr_en <= (aw_sel == SEL_WINDOW);
          end
        end
        W_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          ext_mem_wr_en <= 1'b0;
          case (wr_sel)
            SEL_CTRL: begin
              ctrl_reg <= wr_data;
              start    <= wr_data[0] & ~busy;
            end
            SEL_SIM_TIME: sim_time <= wr_data;
            SEL_MEM_CFG:  mem_cfg  <= wr_data;
            default: ;
          endcase
`ifdef SNN_AXI_SLVERR_EN
          S_AXI_BRESP <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
`else
          S_AXI_BRESP <= RESP_OKAY;
`endif
          S_AXI_BVALID <= 1'b1;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: fixed ACK -> FETCH -> RESP pipeline so window and register
  // reads share the same two-cycle ARREADY-to-RVALID latency.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      rd_addr       <= '0;
      ext_mem_rd_en <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && !wr_go) begin
            r_state       <= R_ACK;
            S_AXI_ARREADY <= 1'b1;
            rd_addr       <= S_AXI_ARADDR;
            ext_mem_rd_en <= (ar_sel == SEL_WINDOW);
          end
        end
        R_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          ext_mem_rd_en <= 1'b0;
          r_state       <= R_FETCH;
        end
        R_FETCH: begin
          case (rd_sel)
            SEL_CTRL:     S_AXI_RDATA <= ctrl_reg;
            SEL_SIM_TIME: S_AXI_RDATA <= sim_time;
            SEL_MEM_CFG:  S_AXI_RDATA <= mem_cfg;
            SEL_DEBUG:    S_AXI_RDATA <= {{(DW-1){1'b0}}, busy};
            SEL_WINDOW:   S_AXI_RDATA <= ext_mem_rdata;
            default:      S_AXI_RDATA <= '0;
          endcase
`ifdef SNN_AXI_SLVERR_EN
          S_AXI_RRESP <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
`else
          S_AXI_RRESP <= RESP_OKAY;
`endif
          S_AXI_RVALID <= 1'b1;
          r_state      <= R_RESP;
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_axi_cfg_slave.sv
// tb_snn_axi_cfg_slave: randomized self-checking bench for snn_axi_cfg_slave.
// Expected values come from a register/memory model of the address map.
// Define SNN_AXI_SLVERR_EN for both bench and design to test the SLVERR build.
module tb_snn_axi_cfg_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ctrl_reg;
  logic [31:0] sim_time;
  logic [31:0] mem_cfg;
  logic        start;
  logic        busy;
  logic        ext_mem_wr_en;
  logic        ext_mem_rd_en;
  logic [7:0]  ext_mem_addr;
  logic [31:0] ext_mem_wdata;
  logic [31:0] ext_mem_rdata;

  int tests  = 0;
  int failed = 0;

  // environment memory behind the window, and the model's view of it
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  logic [31:0] exp_ctrl, exp_sim, exp_cfg;

  // monitor results
  int          start_cnt = 0;
  int          wr_cnt    = 0;
  int          rd_cnt    = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic [7:0]  last_rd_addr;

  always #5 clk = ~clk;

  snn_axi_cfg_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_reg      (ctrl_reg),
    .sim_time      (sim_time),
    .mem_cfg       (mem_cfg),
    .start         (start),
    .busy          (busy),
    .ext_mem_wr_en (ext_mem_wr_en),
    .ext_mem_rd_en (ext_mem_rd_en),
    .ext_mem_addr  (ext_mem_addr),
    .ext_mem_wdata (ext_mem_wdata),
    .ext_mem_rdata (ext_mem_rdata)
  );

  // external memory: one-cycle read latency, writes land on the strobe
  always @(posedge clk) begin
    if (ext_mem_rd_en) ext_mem_rdata <= mem[ext_mem_addr];
  end

  // count pulses (one count per high cycle) and record window traffic
  always @(negedge clk) begin
    if (start) start_cnt++;
    if (ext_mem_wr_en) begin
      wr_cnt++;
      last_wr_addr = ext_mem_addr;
      last_wr_data = ext_mem_wdata;
      mem[ext_mem_addr] = ext_mem_wdata;
    end
    if (ext_mem_rd_en) begin
      rd_cnt++;
      last_rd_addr = ext_mem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic is_unmapped(input logic [15:0] a);
    return (a >= 16'h0010 && a < 16'h0100) || (a >= 16'h0200);
  endfunction

  function automatic logic [1:0] model_resp(input logic [15:0] a);
`ifdef SNN_AXI_SLVERR_EN
    if (is_unmapped(a)) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a < 16'h0010) begin
      case (a[3:2])
        2'd0: return exp_ctrl;
        2'd1: return exp_sim;
        2'd2: return exp_cfg;
        default: return {31'b0, busy};
      endcase
    end
    if (a >= 16'h0100 && a < 16'h0200) return exp_mem[a[7:0]];
    return 32'h0;
  endfunction

  function automatic int model_write(input logic [15:0] a, input logic [31:0] d);
    int pulses;
    pulses = 0;
    if (a < 16'h0010) begin
      case (a[3:2])
        2'd0: begin exp_ctrl = d; pulses = (d[0] && !busy) ? 1 : 0; end
        2'd1: exp_sim = d;
        2'd2: exp_cfg = d;
        default: ;
      endcase
    end else if (a >= 16'h0100 && a < 16'h0200) begin
      exp_mem[a[7:0]] = d;
    end
    return pulses;
  endfunction

  function automatic void model_reset();
    exp_ctrl = '0;
    exp_sim  = '0;
    exp_cfg  = '0;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'($urandom); awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) begin
      tests++; failed++;
      $display("FAIL write_accept addr=%h: AWREADY=%b after 20 cycles, required 1", a, awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin
      tests++; failed++;
      $display("FAIL write_bvalid addr=%h: BVALID=%b after 20 cycles, required 1", a, bvalid);
    end
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) begin
      tests++; failed++;
      $display("FAIL read_accept addr=%h: ARREADY=%b after 20 cycles, required 1", a, arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
    if (!rvalid) begin
      tests++; failed++;
      $display("FAIL read_rvalid addr=%h: RVALID=%b after 20 cycles, required 1", a, rvalid);
    end
    d = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({awready, wready, bvalid, arready, rvalid, start, ext_mem_wr_en, ext_mem_rd_en} !== 8'h00) begin
      failed++;
      $display("FAIL reset_handshake: ready/valid/strobes=%b, required 00000000",
               {awready, wready, bvalid, arready, rvalid, start, ext_mem_wr_en, ext_mem_rd_en});
    end
    tests++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      failed++;
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h, required 0", bresp, rresp, rdata);
    end
    tests++;
    if ({ctrl_reg, sim_time, mem_cfg} !== 96'h0) begin
      failed++;
      $display("FAIL reset_regs: ctrl=%h sim=%h cfg=%h, required 0", ctrl_reg, sim_time, mem_cfg);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({awready, arready, bvalid, rvalid, start} !== 5'b0) begin
      failed++;
      $display("FAIL reset_idle: awready/arready/bvalid/rvalid/start=%b, required 00000",
               {awready, arready, bvalid, rvalid, start});
    end
    model_reset();
  endtask

  task automatic test_regs();
    logic [15:0] a;
    logic [31:0] d, got;
    logic [1:0]  resp;
    int          lat, s0, r0, pulses;
    busy = 1'b0;
    // fixed vectors first, then random register traffic
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin a = 16'h0000; d = 32'hDEADBEEF; end
      else if (i == 1) begin a = 16'h0008; d = 32'h00010A01; end
      else begin a = 16'(4 * $urandom_range(0, 3)); d = $urandom; end
      s0 = start_cnt;
      pulses = model_write(a, d);
      axi_write(a, d, resp);
      tests++;
      if (resp !== 2'b00) begin
        failed++; $display("FAIL reg_bresp addr=%h: got %b, required 00", a, resp);
      end
      tests++;
      if ({ctrl_reg, sim_time, mem_cfg} !== {exp_ctrl, exp_sim, exp_cfg}) begin
        failed++;
        $display("FAIL reg_ports addr=%h: ctrl=%h sim=%h cfg=%h, required %h %h %h",
                 a, ctrl_reg, sim_time, mem_cfg, exp_ctrl, exp_sim, exp_cfg);
      end
      tests++;
      if (start_cnt - s0 != pulses) begin
        failed++; $display("FAIL start_pulse addr=%h data=%h: %0d cycles, required %0d", a, d, start_cnt - s0, pulses);
      end
      a = (i == 0) ? 16'h0000 : 16'(4 * $urandom_range(0, 3));
      r0 = rd_cnt;
      axi_read(a, got, resp, lat);
      tests++;
      if (got !== model_read(a) || resp !== 2'b00) begin
        failed++; $display("FAIL reg_read addr=%h: data=%h resp=%b, required %h 00", a, got, resp, model_read(a));
      end
      tests++;
      if (lat != 2 || rd_cnt != r0) begin
        failed++; $display("FAIL reg_read_timing addr=%h: latency=%0d rd_en cycles=%0d, required 2 and 0", a, lat, rd_cnt - r0);
      end
    end
  endtask

  task automatic test_window();
    logic [15:0] a;
    logic [31:0] d, got;
    logic [1:0]  resp;
    int          lat, w0, r0, dummy;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a = 16'h0105; d = 32'h12345678; end
      else begin a = 16'h0100 | 16'($urandom_range(0, 255)); d = $urandom; end
      w0 = wr_cnt;
      dummy = model_write(a, d);
      axi_write(a, d, resp);
      tests++;
      if (wr_cnt - w0 != 1 || last_wr_addr !== a[7:0] || last_wr_data !== d) begin
        failed++;
        $display("FAIL win_write addr=%h: wr_en cycles=%0d addr=%h data=%h, required 1 %h %h",
                 a, wr_cnt - w0, last_wr_addr, last_wr_data, a[7:0], d);
      end
      tests++;
      if (resp !== 2'b00) begin
        failed++; $display("FAIL win_bresp addr=%h: got %b, required 00", a, resp);
      end
    end
    mem[3] = 32'hCAFEF00D;
    exp_mem[3] = 32'hCAFEF00D;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) a = 16'h0103;
      else if (i == 1) a = 16'h0105;
      else a = 16'h0100 | 16'($urandom_range(0, 255));
      r0 = rd_cnt;
      axi_read(a, got, resp, lat);
      tests++;
      if (got !== model_read(a) || resp !== 2'b00) begin
        failed++; $display("FAIL win_read addr=%h: data=%h resp=%b, required %h 00", a, got, resp, model_read(a));
      end
      tests++;
      if (lat != 2 || rd_cnt - r0 != 1 || last_rd_addr !== a[7:0]) begin
        failed++;
        $display("FAIL win_read_timing addr=%h: latency=%0d rd_en cycles=%0d addr=%h, required 2 1 %h",
                 a, lat, rd_cnt - r0, last_rd_addr, a[7:0]);
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] got;
    logic [1:0]  resp;
    int          lat, s0, pulses;
    busy = 1'b1;
    s0 = start_cnt;
    pulses = model_write(16'h0000, 32'h1);
    axi_write(16'h0000, 32'h1, resp);
    tests++;
    if (ctrl_reg !== 32'h1 || start_cnt - s0 != pulses) begin
      failed++; $display("FAIL busy_ctrl: ctrl=%h start cycles=%0d, required 00000001 %0d", ctrl_reg, start_cnt - s0, pulses);
    end
    axi_read(16'h000C, got, resp, lat);
    tests++;
    if (got !== 32'h1) begin
      failed++; $display("FAIL debug_busy1: got %h, required 00000001", got);
    end
    busy = 1'b0;
    axi_read(16'h000C, got, resp, lat);
    tests++;
    if (got !== 32'h0) begin
      failed++; $display("FAIL debug_busy0: got %h, required 00000000", got);
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] a;
    logic [31:0] got;
    logic [1:0]  resp;
    int          lat, w0, dummy;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) a = 16'h0300;
      else if (i == 1) a = 16'h0020;
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(16, 255));
      else a = 16'($urandom_range(512, 65535));
      axi_read(a, got, resp, lat);
      tests++;
      if (got !== 32'h0 || resp !== model_resp(a) || lat != 2) begin
        failed++;
        $display("FAIL unmapped_read addr=%h: data=%h resp=%b latency=%0d, required 0 %b 2", a, got, resp, lat, model_resp(a));
      end
      w0 = wr_cnt;
      dummy = model_write(a, 32'hFFFF_FFFF);
      axi_write(a, 32'hFFFF_FFFF, resp);
      tests++;
      if (resp !== model_resp(a) || wr_cnt != w0 ||
          {ctrl_reg, sim_time, mem_cfg} !== {exp_ctrl, exp_sim, exp_cfg}) begin
        failed++;
        $display("FAIL unmapped_write addr=%h: resp=%b wr_en cycles=%0d ctrl=%h sim=%h cfg=%h, required %b 0 %h %h %h",
                 a, resp, wr_cnt - w0, ctrl_reg, sim_time, mem_cfg, model_resp(a), exp_ctrl, exp_sim, exp_cfg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    int          n, dummy;
    d1 = $urandom;
    d2 = $urandom;
    @(negedge clk);
    awaddr = 16'h0004; wdata = d1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    dummy = model_write(16'h0004, d1);
    // second write queued while the first response is stalled
    awaddr = 16'h0008; wdata = d2;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        failed++; $display("FAIL bp_hold cycle %0d: bvalid=%b awready=%b, required 1 0", i, bvalid, awready);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (awready !== 1'b1) begin
      failed++; $display("FAIL bp_second_accept: awready=%b, required 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    dummy = model_write(16'h0008, d2);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    tests++;
    if (sim_time !== exp_sim || mem_cfg !== exp_cfg) begin
      failed++; $display("FAIL bp_regs: sim=%h cfg=%h, required %h %h", sim_time, mem_cfg, exp_sim, exp_cfg);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d, exp_rd;
    int          n, dummy;
    d = $urandom;
    exp_rd = model_read(16'h0008);
    @(negedge clk);
    awaddr = 16'h0004; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 16'h0008; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    tests++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      failed++; $display("FAIL collide_first: awready=%b arready=%b, required 1 0", awready, arready);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    dummy = model_write(16'h0004, d);
    @(negedge clk);
    tests++;
    if (arready !== 1'b1) begin
      failed++; $display("FAIL collide_read_delay: arready=%b, required 1", arready);
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (rdata !== exp_rd || sim_time !== exp_sim) begin
      failed++; $display("FAIL collide_data: rdata=%h sim=%h, required %h %h", rdata, sim_time, exp_rd, exp_sim);
    end
    @(negedge clk);
  endtask

  task automatic test_read_hold();
    logic [31:0] held;
    int          n;
    @(negedge clk);
    araddr = 16'h0004; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    held = rdata;
    tests++;
    if (rvalid !== 1'b1 || held !== model_read(16'h0004)) begin
      failed++; $display("FAIL hold_first: rvalid=%b rdata=%h, required 1 %h", rvalid, held, model_read(16'h0004));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (rvalid !== 1'b1 || rdata !== held || arready !== 1'b0) begin
        failed++; $display("FAIL hold_stable cycle %0d: rvalid=%b rdata=%h arready=%b, required 1 %h 0", i, rvalid, rdata, arready, held);
      end
    end
    rready = 1'b1; arvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (rvalid !== 1'b0) begin
      failed++; $display("FAIL hold_release: rvalid=%b, required 0", rvalid);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] got;
    logic [1:0]  resp;
    int          n, lat;
    // reset in the middle of a window read
    @(negedge clk);
    araddr = 16'h0100 | 16'($urandom_range(0, 255)); arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rvalid, arready, ext_mem_rd_en} !== 3'b000 || ctrl_reg !== 32'h0) begin
      failed++; $display("FAIL rst_mid_read: rvalid/arready/rd_en=%b ctrl=%h, required 000 0", {rvalid, arready, ext_mem_rd_en}, ctrl_reg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (rvalid !== 1'b0) begin
        failed++; $display("FAIL rst_no_response cycle %0d: rvalid=%b, required 0", i, rvalid);
      end
    end
    // reset while a write response is stalled
    @(negedge clk);
    awaddr = 16'h0004; wdata = $urandom; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bvalid !== 1'b0 || sim_time !== 32'h0) begin
      failed++; $display("FAIL rst_mid_write: bvalid=%b sim=%h, required 0 0", bvalid, sim_time);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    model_reset();
    axi_read(16'h0000, got, resp, lat);
    tests++;
    if (got !== model_read(16'h0000) || lat != 2) begin
      failed++; $display("FAIL rst_recover: data=%h latency=%0d, required %h 2", got, lat, model_read(16'h0000));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; busy = 1'b0; ext_mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_regs();
    test_window();
    test_busy();
    test_unmapped();
    test_back_to_back();
    test_collision();
    test_read_hold();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
